// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle Moore FSM sequencing fetch, decode, execute,
//               memory and write-back strobes for a simple 32-bit datapath.
//               Optional macro CU_BRANCH_LINK_EN enables opcode 01000
//               (branch-and-link, npc written to R15).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] out_ins,
    input  logic [2:0]  comp_res,
    output logic        en,
    output logic        read,
    output logic        write,
    output logic        writeport,
    output logic        writedata,
    output logic        src1,
    output logic        src2,
    output logic        ld_lmd,
    output logic        en_data_mem,
    output logic        wri_data_mem,
    output logic        en_ins_mem,
    output logic        selcomp,
    output logic        selPC,
    output logic        ld_pc,
    output logic        resetPC,
    output logic        reset_all,
    output logic        load_ir,
    output logic        isbranch,
    output logic [4:0]  alu_func,
    output logic [1:0]  selsig,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [4:0] C_OP_RALU = 5'b00000;
    localparam logic [4:0] C_OP_ADDI = 5'b00001;
    localparam logic [4:0] C_OP_LD   = 5'b00010;
    localparam logic [4:0] C_OP_ST   = 5'b00011;
    localparam logic [4:0] C_OP_J    = 5'b00100;
    localparam logic [4:0] C_OP_BEQ  = 5'b00101;
    localparam logic [4:0] C_OP_BLTZ = 5'b00110;
    localparam logic [4:0] C_OP_BGTZ = 5'b00111;
    localparam logic [4:0] C_OP_BL   = 5'b01000;
    localparam logic [4:0] C_OP_HALT = 5'b11111;

    // PC-source select: 00 follows selPC, otherwise a compare flag
    localparam logic [1:0] C_SEL_PC = 2'b00;
    localparam logic [1:0] C_SEL_LT = 2'b01;
    localparam logic [1:0] C_SEL_EQ = 2'b10;
    localparam logic [1:0] C_SEL_GT = 2'b11;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_illegal;
    logic       w_illegal_nxt;
    logic [4:0] w_opcode;
    logic       w_op_known;
    logic       w_unused;

    assign w_opcode = out_ins[31:27];

    // Compare flags are consumed by the datapath PC mux, not by this FSM
    assign w_unused = ^{comp_res, out_ins[26:5]};

    // Opcodes that decode to a real instruction (HALT is handled separately)
    always_comb begin
        w_op_known = 1'b0;
        case (w_opcode)
            C_OP_RALU, C_OP_ADDI, C_OP_LD, C_OP_ST,
            C_OP_J, C_OP_BEQ, C_OP_BLTZ, C_OP_BGTZ: w_op_known = 1'b1;
`ifdef CU_BRANCH_LINK_EN
            C_OP_BL:                                w_op_known = 1'b1;
`endif
            default:                                w_op_known = 1'b0;
        endcase
    end

    // State and illegal-flag registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    // Next-state and Moore output decode; reset overrides every strobe
    always_comb begin
        w_state_nxt   = r_state;
        w_illegal_nxt = r_illegal;
        en            = 1'b0;
        read          = 1'b0;
        write         = 1'b0;
        writeport     = 1'b0;
        writedata     = 1'b0;
        src1          = 1'b0;
        src2          = 1'b0;
        ld_lmd        = 1'b0;
        en_data_mem   = 1'b0;
        wri_data_mem  = 1'b0;
        en_ins_mem    = 1'b0;
        selcomp       = 1'b0;
        selPC         = 1'b0;
        ld_pc         = 1'b0;
        resetPC       = 1'b0;
        reset_all     = 1'b0;
        load_ir       = 1'b0;
        isbranch      = 1'b0;
        alu_func      = 5'b00000;
        selsig        = C_SEL_PC;
        halted        = 1'b0;
        illegal       = 1'b0;
        if (!reset_n) begin
            reset_all = 1'b1;
            resetPC   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    en_ins_mem  = 1'b1;
                    load_ir     = 1'b1;
                    w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    en   = 1'b1;
                    read = 1'b1;
                    if (w_opcode == C_OP_HALT) begin
                        w_state_nxt   = S_HALT;
                        w_illegal_nxt = 1'b0;
                    end else if (w_op_known) begin
                        w_state_nxt   = S_EXEC;
                    end else begin
                        w_state_nxt   = S_HALT;
                        w_illegal_nxt = 1'b1;
                    end
                end
                S_EXEC: begin
                    w_state_nxt = S_FETCH;
                    case (w_opcode)
                        C_OP_RALU: begin
                            alu_func    = out_ins[4:0];
                            src1        = 1'b1;
                            src2        = 1'b1;
                            w_state_nxt = S_WB;
                        end
                        C_OP_ADDI: begin
                            src1        = 1'b1;
                            w_state_nxt = S_WB;
                        end
                        C_OP_LD, C_OP_ST: begin
                            src1        = 1'b1;
                            w_state_nxt = S_MEM;
                        end
                        C_OP_J: begin
                            ld_pc = 1'b1;
                            selPC = 1'b1;
                        end
                        C_OP_BEQ: begin
                            ld_pc  = 1'b1;
                            selsig = C_SEL_EQ;
                        end
                        C_OP_BLTZ: begin
                            ld_pc   = 1'b1;
                            selcomp = 1'b1;
                            selsig  = C_SEL_LT;
                        end
                        C_OP_BGTZ: begin
                            ld_pc   = 1'b1;
                            selcomp = 1'b1;
                            selsig  = C_SEL_GT;
                        end
`ifdef CU_BRANCH_LINK_EN
                        C_OP_BL: begin
                            ld_pc    = 1'b1;
                            selPC    = 1'b1;
                            isbranch = 1'b1;
                            en       = 1'b1;
                            write    = 1'b1;
                        end
`endif
                        default: w_state_nxt = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    en_data_mem = 1'b1;
                    if (w_opcode == C_OP_LD) begin
                        ld_lmd      = 1'b1;
                        w_state_nxt = S_WB;
                    end else begin
                        wri_data_mem = 1'b1;
                        ld_pc        = 1'b1;
                        w_state_nxt  = S_FETCH;
                    end
                end
                S_WB: begin
                    en          = 1'b1;
                    write       = 1'b1;
                    ld_pc       = 1'b1;
                    writeport   = (w_opcode == C_OP_RALU);
                    writedata   = (w_opcode == C_OP_RALU) || (w_opcode == C_OP_ADDI);
                    w_state_nxt = S_FETCH;
                end
                S_HALT: begin
                    halted  = 1'b1;
                    illegal = r_illegal;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
